pwm_duty_decoder: RTL and testbench

- Receive-side counterpart of the PWM generator: samples an incoming PWM waveform and measures period and high time in clk cycles.
- Computes the duty cycle in tenths (0..10), the same unit the generator's DUTY_CYCLE uses.
- Used to loop back or check the generator on-chip, and to decode an external PWM input.

---
 rtl/pwm_duty_decoder.sv | 155 +++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an asynchronous PWM input and reports the
// duty cycle in tenths (0..10) through a 4-step restoring divider.
module pwm_duty_decoder #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ui_pwm_in,
  input  logic          ui_clear,
  output logic [3:0]    uo_duty,
  output logic [CW-1:0] uo_period,
  output logic [CW-1:0] uo_high,
  output logic          uo_valid,
  output logic          uo_overrun,
  output logic          uo_locked,
  output logic [1:0]    dbg_state
);

  localparam int DW = CW + 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    RUN   = 2'd1,
    STUCK = 2'd2
  } state_t;

  state_t        state;
  logic          sync_q;
  logic          s;
  logic          s_d;
  logic          rise;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] high_cnt;

  logic          busy;
  logic [1:0]    step;
  logic [DW-1:0] rem;
  logic [DW-1:0] div_p;
  logic [3:0]    quo;
  logic [CW-1:0] cap_p;
  logic [CW-1:0] cap_h;

  logic [DW-1:0] shifted;
  logic          ge;
  logic [3:0]    quo_next;
  logic          drop;

  assign rise      = s & ~s_d;
  assign drop      = (state == RUN) && rise && busy;
  assign dbg_state = state;

  // One restoring-division step: trial subtract of P shifted by the current bit.
  always_comb begin
    shifted        = div_p << step;
    ge             = (rem >= shifted);
    quo_next       = quo;
    quo_next[step] = ge;
  end

  // uo_valid is a one-cycle pulse; there is no back-pressure, so a consumer
  // must take uo_duty/uo_period/uo_high in the cycle uo_valid is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARM;
      sync_q     <= 1'b0;
      s          <= 1'b0;
      s_d        <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      busy       <= 1'b0;
      step       <= 2'd0;
      rem        <= '0;
      div_p      <= '0;
      quo        <= 4'd0;
      cap_p      <= '0;
      cap_h      <= '0;
      uo_duty    <= 4'd0;
      uo_period  <= '0;
      uo_high    <= '0;
      uo_valid   <= 1'b0;
      uo_overrun <= 1'b0;
      uo_locked  <= 1'b0;
    end else begin
      sync_q   <= ui_pwm_in;
      s        <= sync_q;
      s_d      <= s;
      uo_valid <= 1'b0;

      case (state)
        ARM, STUCK: begin
          if (rise) begin
            period_cnt <= {{(CW-1){1'b0}}, 1'b1};
            high_cnt   <= {{(CW-1){1'b0}}, 1'b1};
            state      <= RUN;
            uo_locked  <= 1'b1;
          end
        end
        RUN: begin
          if (rise) begin
            period_cnt <= {{(CW-1){1'b0}}, 1'b1};
            high_cnt   <= {{(CW-1){1'b0}}, 1'b1};
            if (!busy) begin
              busy  <= 1'b1;
              step  <= 2'd3;
              quo   <= 4'd0;
              rem   <= ({4'd0, high_cnt} << 3) + ({4'd0, high_cnt} << 1);
              div_p <= {4'd0, period_cnt};
              cap_p <= period_cnt;
              cap_h <= high_cnt;
            end
          end else if (period_cnt == CNT_MAX) begin
            // No edge for a full counter range: report a flat line.
            state     <= STUCK;
            uo_locked <= 1'b0;
            uo_period <= '0;
            uo_high   <= '0;
            uo_duty   <= s ? 4'd10 : 4'd0;
            uo_valid  <= 1'b1;
          end else begin
            period_cnt <= period_cnt + 1'b1;
            if (s && (high_cnt != CNT_MAX))
              high_cnt <= high_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ARM;
          uo_locked <= 1'b0;
        end
      endcase

      if (busy) begin
        if (ge)
          rem <= rem - shifted;
        quo <= quo_next;
        if (step == 2'd0) begin
          busy      <= 1'b0;
          uo_duty   <= (quo_next > 4'd10) ? 4'd10 : quo_next;
          uo_period <= cap_p;
          uo_high   <= cap_h;
          uo_valid  <= 1'b1;
        end else begin
          step <= step - 2'd1;
        end
      end

      // A dropped measurement beats a simultaneous clear.
      if (drop)
        uo_overrun <= 1'b1;
      else if (ui_clear)
        uo_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed and random PWM stimulus for pwm_duty_decoder; a behavioural edge
// model predicts each measurement and its arrival cycle.
module tb_pwm_duty_decoder;
  localparam int CW = 8;
  localparam int W  = 4 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ui_pwm_in = 1'b0;
  logic          ui_clear = 1'b0;
  logic [3:0]    uo_duty;
  logic [CW-1:0] uo_period;
  logic [CW-1:0] uo_high;
  logic          uo_valid;
  logic          uo_overrun;
  logic          uo_locked;
  logic [1:0]    dbg_state;

  pwm_duty_decoder #(.CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_pwm_in  (ui_pwm_in),
    .ui_clear   (ui_clear),
    .uo_duty    (uo_duty),
    .uo_period  (uo_period),
    .uo_high    (uo_high),
    .uo_valid   (uo_valid),
    .uo_overrun (uo_overrun),
    .uo_locked  (uo_locked),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] mon_e;
  int           mon_d;

  // Edge model state
  bit   armed = 1'b0;
  bit   exp_ovr = 1'b0;
  logic pwm_prev = 1'b0;
  int   last_rise = 0;
  int   last_load = -100;
  int   h_acc = 0;

  function automatic int duty_of(input int h, input int p);
    int q;
    q = (10 * h) / p;
    return (q > 10) ? 10 : q;
  endfunction

  task automatic push_exp(input int duty, input int p, input int h, input int due);
    logic [3:0]    d4;
    logic [CW-1:0] pv;
    logic [CW-1:0] hv;
    d4 = duty[3:0];
    pv = p[CW-1:0];
    hv = h[CW-1:0];
    exp_q.push_back({d4, pv, hv});
    due_q.push_back(due);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one clk cycle of PWM level and advance the model.
  task automatic step(input logic lv);
    int t;
    @(posedge clk);
    #1;
    ui_pwm_in = lv;
    t = cyc;
    if (lv && !pwm_prev) begin
      if (armed) begin
        if (t - last_load >= 5) begin
          push_exp(duty_of(h_acc, t - last_rise), t - last_rise, h_acc, t + 7);
          last_load = t;
        end else begin
          exp_ovr = 1'b1;
        end
      end
      armed     = 1'b1;
      last_rise = t;
      h_acc     = 1;
    end else if (armed) begin
      if (t - last_rise == 255) begin
        push_exp(lv ? 10 : 0, 0, 0, t + 3);
        armed = 1'b0;
      end else begin
        h_acc += int'(lv);
      end
    end
    pwm_prev = lv;
  endtask

  task automatic pwm(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++)
        step(i < h);
  endtask

  task automatic idle(input logic lv, input int n);
    for (int i = 0; i < n; i++)
      step(lv);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    ui_pwm_in = 1'b0;
    pwm_prev  = 1'b0;
    armed     = 1'b0;
    exp_ovr   = 1'b0;
    last_load = -100;
    exp_q.delete();
    due_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_duty"},    int'(uo_duty),    0);
    chk({tag, "_period"},  int'(uo_period),  0);
    chk({tag, "_high"},    int'(uo_high),    0);
    chk({tag, "_valid"},   int'(uo_valid),   0);
    chk({tag, "_overrun"}, int'(uo_overrun), 0);
    chk({tag, "_locked"},  int'(uo_locked),  0);
    chk({tag, "_state"},   int'(dbg_state),  0);
  endtask

  // Monitor: pop and compare on every valid pulse, including arrival cycle.
  always @(negedge clk) begin
    if (rst_n && uo_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $error("FAIL unexpected_valid observed duty=%0d period=%0d high=%0d expected none",
               uo_duty, uo_period, uo_high);
      end else begin
        mon_e = exp_q.pop_front();
        mon_d = due_q.pop_front();
        assert ({uo_duty, uo_period, uo_high} === mon_e) else begin
          miscompares++;
          $error("FAIL measurement observed duty=%0d period=%0d high=%0d expected duty=%0d period=%0d high=%0d",
                 uo_duty, uo_period, uo_high, mon_e[W-1 -: 4], mon_e[2*CW-1 -: CW], mon_e[CW-1:0]);
        end
        vectors++;
        assert (cyc == mon_d) else begin
          miscompares++;
          $error("FAIL latency observed cycle=%0d expected cycle=%0d", cyc, mon_d);
        end
      end
    end
  end

  initial begin
    int p;
    int h;

    do_reset(4);
    check_zero("reset");
    idle(1'b0, 5);

    // Loopback-style 10/5 waveform: first rise arms, later rises measure.
    pwm(10, 5, 6);
    chk("locked_run", int'(uo_locked), 1);
    chk("state_run", int'(dbg_state), 1);

    for (int k = 1; k <= 9; k++)
      pwm(10, k, 3);

    pwm(7, 3, 4);

    // Held high after locking: flat-line report with duty 10.
    pwm(10, 5, 2);
    idle(1'b1, 300);
    chk("locked_stuck_hi", int'(uo_locked), 0);
    chk("state_stuck_hi", int'(dbg_state), 2);

    // Held low after locking: flat-line report with duty 0.
    pwm(10, 5, 3);
    idle(1'b0, 300);
    chk("locked_stuck_lo", int'(uo_locked), 0);
    chk("duty_stuck_lo", int'(uo_duty), 0);

    // Resume: first rise re-arms, following ones measure.
    pwm(10, 5, 4);
    chk("locked_resume", int'(uo_locked), 1);

    // Too-short period: every other rise is dropped.
    pwm(3, 1, 8);
    idle(1'b0, 20);
    chk("overrun_set", int'(uo_overrun), int'(exp_ovr));
    chk("overrun_model", int'(exp_ovr), 1);
    ui_clear = 1'b1;
    step(1'b0);
    ui_clear = 1'b0;
    exp_ovr  = 1'b0;
    idle(1'b0, 5);
    chk("overrun_clear", int'(uo_overrun), 0);
    idle(1'b0, 260);

    for (int k = 0; k < 12; k++) begin
      p = $urandom_range(20, 5);
      h = $urandom_range(p - 1, 1);
      pwm(p, h, 1);
    end
    chk("locked_random", int'(uo_locked), 1);

    // Reset two cycles into a division: nothing may be reported.
    idle(1'b0, 10);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    do_reset(2);
    check_zero("midreset");
    idle(1'b0, 20);
    check_zero("postreset");

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
